// File: rtl/meikyuu_pkg.sv
// meikyuu_pkg: types and constants shared by the maze-game blocks.
//   - move_state_e : movement controller FSM state encoding
//   - axis_e/dir_e : move axis and sign (DIR_POS = right / down)
//   - screen bounds and sprite size, also used by the VGA renderer
//   - BTN_* : bit positions in the packed {up, down, left, right} button vector
package meikyuu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } move_state_e;

  typedef enum logic {
    AXIS_V = 1'b0,
    AXIS_H = 1'b1
  } axis_e;

  typedef enum logic {
    DIR_NEG = 1'b0,  // up or left
    DIR_POS = 1'b1   // down or right
  } dir_e;

  // Play-field origin and extent in pixels; the sprite must stay fully inside.
  localparam int SCREEN_X0   = 96;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_Y0   = 2;
  localparam int SCREEN_H    = 480;
  localparam int SPRITE_SIZE = 16;

  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

endpackage

// File: rtl/move_ctrl_dir_arbiter.sv
// dir_arbiter: reduces four button levels to one move.
//   Opposite buttons on one axis cancel. When both axes request, the
//   round-robin axis (rr_axis, reset vertical) wins and then flips.
// Ports:
//   clk_i, rst_i         clock, async active-high reset
//   up_i/down_i/left_i/right_i  latched button levels
//   advance_i            high for the one cycle the decision is consumed
//   axis_o, sign_o       chosen axis and direction
//   valid_o              at least one axis has an uncancelled request
module dir_arbiter
  import meikyuu_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  up_i,
  input  logic  down_i,
  input  logic  left_i,
  input  logic  right_i,
  input  logic  advance_i,
  output axis_e axis_o,
  output dir_e  sign_o,
  output logic  valid_o
);

  axis_e rr_axis_q;
  logic  v_req;
  logic  h_req;

  assign v_req = up_i ^ down_i;
  assign h_req = left_i ^ right_i;

  always_comb begin
    valid_o = v_req | h_req;
    if (v_req && h_req) begin
      axis_o = rr_axis_q;
    end else if (h_req) begin
      axis_o = AXIS_H;
    end else begin
      axis_o = AXIS_V;
    end
    if (axis_o == AXIS_H) begin
      sign_o = right_i ? DIR_POS : DIR_NEG;
    end else begin
      sign_o = down_i ? DIR_POS : DIR_NEG;
    end
  end

  // Only a genuine two-axis conflict advances the round robin.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_axis_q <= AXIS_V;
    end else if (advance_i && v_req && h_req) begin
      rr_axis_q <= (rr_axis_q == AXIS_V) ? AXIS_H : AXIS_V;
    end
  end

endmodule

// File: rtl/move_ctrl.sv
// move_ctrl: per-frame player movement controller.
//   On frame_tick (in IDLE) the synchronized buttons are latched and
//   arbitrated to one move. An in-room move is checked by the collision
//   checker; a move off a room edge into an existing neighbour room is a
//   room transition that commits without a check.
// Collision handshake: chk_req rises with chk_x/chk_y stable and stays high,
//   unchanged, until a cycle with chk_ack=1 (which may be the first chk_req
//   cycle). chk_hit is sampled only in that cycle; chk_ack outside CHECK is
//   ignored. With no chk_ack within TIMEOUT cycles the request is withdrawn
//   and the move is treated as a hit.
// Ports:
//   CLOCK_25, reset       clock, async active-high reset
//   frame_tick            one-cycle pulse per frame
//   btn_up/down/left/right  asynchronous buttons
//   chk_req/chk_x/chk_y/chk_ack/chk_hit  collision checker handshake
//   x_pos, y_pos, room_x, room_y  committed position and room
//   busy                  FSM not in IDLE
//   moved                 one-cycle pulse after a commit
//   dbg_state_o           current FSM state
// Build option: MOVE_CTRL_DEBOUNCE_EN requires a button to be high at two
//   consecutive frame_ticks before it counts as pressed.
module move_ctrl
  import meikyuu_pkg::*;
#(
  parameter int STEP         = 2,
  parameter int X_MIN        = SCREEN_X0,
  parameter int X_MAX        = SCREEN_X0 + SCREEN_W - SPRITE_SIZE,
  parameter int Y_MIN        = SCREEN_Y0,
  parameter int Y_MAX        = SCREEN_Y0 + SCREEN_H - SPRITE_SIZE,
  parameter int X_START      = 408,
  parameter int Y_START      = 226,
  parameter int ROOMS_X      = 3,
  parameter int ROOMS_Y      = 3,
  parameter int ROOM_START_X = 1,
  parameter int ROOM_START_Y = 1,
  parameter int TIMEOUT      = 16
) (
  input  logic        CLOCK_25,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic        chk_req,
  output logic [9:0]  chk_x,
  output logic [9:0]  chk_y,
  input  logic        chk_ack,
  input  logic        chk_hit,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [2:0]  room_x,
  output logic [2:0]  room_y,
  output logic        busy,
  output logic        moved,
  output move_state_e dbg_state_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
  localparam logic [2:0]         RX_LAST = 3'(ROOMS_X - 1);
  localparam logic [2:0]         RY_LAST = 3'(ROOMS_Y - 1);

  // ---------------------------------------------------------------- buttons
  logic [3:0] btn_raw;
  logic [3:0] btn_meta_q;
  logic [3:0] btn_sync_q;
  logic [3:0] btn_qual;
  logic [3:0] btn_lat_q;

  assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
    end
  end

`ifdef MOVE_CTRL_DEBOUNCE_EN
  // History of the synchronized level at the previous frame_tick.
  logic [3:0] btn_hist_q;

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      btn_hist_q <= '0;
    end else if (frame_tick) begin
      btn_hist_q <= btn_sync_q;
    end
  end

  assign btn_qual = btn_sync_q & btn_hist_q;
`else
  assign btn_qual = btn_sync_q;
`endif

  // -------------------------------------------------------------- arbiter
  move_state_e state_q;
  axis_e       arb_axis;
  dir_e        arb_sign;
  logic        arb_valid;

  dir_arbiter u_arb (
    .clk_i     (CLOCK_25),
    .rst_i     (reset),
    .up_i      (btn_lat_q[BTN_UP]),
    .down_i    (btn_lat_q[BTN_DOWN]),
    .left_i    (btn_lat_q[BTN_LEFT]),
    .right_i   (btn_lat_q[BTN_RIGHT]),
    .advance_i (state_q == ST_ARB),
    .axis_o    (arb_axis),
    .sign_o    (arb_sign),
    .valid_o   (arb_valid)
  );

  // ------------------------------------------------------ proposed move
  logic [9:0]         x_pos_q, y_pos_q;
  logic [2:0]         room_x_q, room_y_q;
  logic signed [10:0] cur_s;
  logic signed [10:0] prop_s;
  logic               in_range;
  logic               has_nbr;
  logic [9:0]         nxt_x, nxt_y;
  logic [2:0]         nxt_rx, nxt_ry;

  always_comb begin
    nxt_x  = x_pos_q;
    nxt_y  = y_pos_q;
    nxt_rx = room_x_q;
    nxt_ry = room_y_q;
    cur_s  = (arb_axis == AXIS_H) ? $signed({1'b0, x_pos_q}) : $signed({1'b0, y_pos_q});
    prop_s = (arb_sign == DIR_POS) ? cur_s + STEP_S : cur_s - STEP_S;
    if (arb_axis == AXIS_H) begin
      in_range = (prop_s >= X_MIN_S) && (prop_s <= X_MAX_S);
      has_nbr  = (arb_sign == DIR_POS) ? (room_x_q != RX_LAST) : (room_x_q != 3'd0);
      if (in_range) begin
        nxt_x = prop_s[9:0];
      end else begin
        // Entering the neighbour room puts the sprite at its far edge.
        nxt_x  = (arb_sign == DIR_POS) ? 10'(X_MIN) : 10'(X_MAX);
        nxt_rx = (arb_sign == DIR_POS) ? room_x_q + 3'd1 : room_x_q - 3'd1;
      end
    end else begin
      in_range = (prop_s >= Y_MIN_S) && (prop_s <= Y_MAX_S);
      has_nbr  = (arb_sign == DIR_POS) ? (room_y_q != RY_LAST) : (room_y_q != 3'd0);
      if (in_range) begin
        nxt_y = prop_s[9:0];
      end else begin
        nxt_y  = (arb_sign == DIR_POS) ? 10'(Y_MIN) : 10'(Y_MAX);
        nxt_ry = (arb_sign == DIR_POS) ? room_y_q + 3'd1 : room_y_q - 3'd1;
      end
    end
  end

  // ------------------------------------------------------------------ FSM
  logic [9:0]       tgt_x_q, tgt_y_q;
  logic [2:0]       tgt_rx_q, tgt_ry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             chk_req_q, busy_q, moved_q;
  logic [9:0]       chk_x_q, chk_y_q;

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_pos_q   <= 10'(X_START);
      y_pos_q   <= 10'(Y_START);
      room_x_q  <= 3'(ROOM_START_X);
      room_y_q  <= 3'(ROOM_START_Y);
      tgt_x_q   <= 10'(X_START);
      tgt_y_q   <= 10'(Y_START);
      tgt_rx_q  <= 3'(ROOM_START_X);
      tgt_ry_q  <= 3'(ROOM_START_Y);
      btn_lat_q <= '0;
      cnt_q     <= '0;
      chk_req_q <= 1'b0;
      chk_x_q   <= '0;
      chk_y_q   <= '0;
      busy_q    <= 1'b0;
      moved_q   <= 1'b0;
    end else begin
      moved_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_tick) begin
            btn_lat_q <= btn_qual;
            state_q   <= ST_ARB;
            busy_q    <= 1'b1;
          end
        end
        ST_ARB: begin
          tgt_x_q  <= nxt_x;
          tgt_y_q  <= nxt_y;
          tgt_rx_q <= nxt_rx;
          tgt_ry_q <= nxt_ry;
          if (!arb_valid) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (!in_range) begin
            // Room edge: cross into the neighbour, or stay put at the world edge.
            if (has_nbr) begin
              state_q <= ST_COMMIT;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            state_q   <= ST_CHECK;
            chk_req_q <= 1'b1;
            chk_x_q   <= nxt_x;
            chk_y_q   <= nxt_y;
            cnt_q     <= '0;
          end
        end
        ST_CHECK: begin
          if (chk_ack) begin
            chk_req_q <= 1'b0;
            if (chk_hit) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_COMMIT;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            chk_req_q <= 1'b0;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          x_pos_q  <= tgt_x_q;
          y_pos_q  <= tgt_y_q;
          room_x_q <= tgt_rx_q;
          room_y_q <= tgt_ry_q;
          moved_q  <= 1'b1;
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign chk_req     = chk_req_q;
  assign chk_x       = chk_x_q;
  assign chk_y       = chk_y_q;
  assign x_pos       = x_pos_q;
  assign y_pos       = y_pos_q;
  assign room_x      = room_x_q;
  assign room_y      = room_y_q;
  assign busy        = busy_q;
  assign moved       = moved_q;
  assign dbg_state_o = state_q;

endmodule
